div_pipe_unit: RTL and testbench

Parametrised, fully pipelined restoring integer divider for the execute-stage DIV/DIVU path. It accepts one divide per cycle and produces quotient, remainder, a divide-by-zero flag and a pass-through tag after a fixed latency. It generalises the single-step division stage to any operand width and any number of quotient bits per pipeline stage. It adds valid/tag tracking, a global clock-enable stall, signed operation and divide-by-zero handling.

---
 rtl/div_pipe_unit.sv | 143 ++++++++++++++
 tb/tb_div_pipe_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_pipe_unit.sv
// Fully pipelined restoring divider: one divide per cycle, latency WIDTH/STEPS_PER_STAGE + 2.
// Define DIV_SIGNED_EN to honour signed_i (sign/magnitude prep and fixup negation).
module div_pipe_unit #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_STAGE = 1,
  parameter int TAG_W           = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int N = WIDTH / STEPS_PER_STAGE;

  // Stage 0 is the prep register, stages 1..N hold the iteration results.
  logic             valid_reg [0:N];
  logic [TAG_W-1:0] tag_reg   [0:N];
  logic [WIDTH-1:0] d_reg     [0:N];
  logic [WIDTH:0]   r_reg     [0:N];
  logic [WIDTH-1:0] q_reg     [0:N];
  logic [WIDTH-1:0] dvd_reg   [0:N];
  logic             q_neg_reg [0:N];
  logic             r_neg_reg [0:N];
  logic             zero_reg  [0:N];

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
  assign dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg = signed_i & divisor_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;
`else
  logic unused_signed;
  assign unused_signed = signed_i;
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
  assign dvd_mag = dividend_i;
  assign dvs_mag = divisor_i;
`endif

  logic [WIDTH:0]   r_nx [0:N-1];
  logic [WIDTH-1:0] q_nx [0:N-1];

  // R carries one extra bit so the shifted partial remainder never overflows the compare.
  always_comb begin : iter_comb
    logic [WIDTH:0]   r_t;
    logic [WIDTH-1:0] q_t;
    r_t = '0;
    q_t = '0;
    for (int i = 0; i < N; i++) begin
      r_t = r_reg[i];
      q_t = q_reg[i];
      for (int s = 0; s < STEPS_PER_STAGE; s++) begin
        r_t = {r_t[WIDTH-1:0], q_t[WIDTH-1]};
        q_t = {q_t[WIDTH-2:0], 1'b0};
        if (r_t >= {1'b0, d_reg[i]}) begin
          r_t    = r_t - {1'b0, d_reg[i]};
          q_t[0] = 1'b1;
        end
      end
      r_nx[i] = r_t;
      q_nx[i] = q_t;
    end
  end

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    q_fix = q_reg[N];
    r_fix = r_reg[N][WIDTH-1:0];
`ifdef DIV_SIGNED_EN
    if (q_neg_reg[N]) q_fix = -q_reg[N];
    if (r_neg_reg[N]) r_fix = -r_reg[N][WIDTH-1:0];
`endif
    if (zero_reg[N]) begin
      q_fix = '1;
      r_fix = dvd_reg[N];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i <= N; i++) begin
        valid_reg[i] <= 1'b0;
        tag_reg[i]   <= '0;
        d_reg[i]     <= '0;
        r_reg[i]     <= '0;
        q_reg[i]     <= '0;
        dvd_reg[i]   <= '0;
        q_neg_reg[i] <= 1'b0;
        r_neg_reg[i] <= 1'b0;
        zero_reg[i]  <= 1'b0;
      end
      out_valid_o <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
      tag_o       <= '0;
    end else if (ce_i) begin
      valid_reg[0] <= in_valid_i;
      tag_reg[0]   <= tag_i;
      d_reg[0]     <= dvs_mag;
      r_reg[0]     <= '0;
      q_reg[0]     <= dvd_mag;
      dvd_reg[0]   <= dividend_i;
      q_neg_reg[0] <= dvd_neg ^ dvs_neg;
      r_neg_reg[0] <= dvd_neg;
      zero_reg[0]  <= (divisor_i == '0);
      for (int i = 0; i < N; i++) begin
        valid_reg[i+1] <= valid_reg[i];
        tag_reg[i+1]   <= tag_reg[i];
        d_reg[i+1]     <= d_reg[i];
        r_reg[i+1]     <= r_nx[i];
        q_reg[i+1]     <= q_nx[i];
        dvd_reg[i+1]   <= dvd_reg[i];
        q_neg_reg[i+1] <= q_neg_reg[i];
        r_neg_reg[i+1] <= r_neg_reg[i];
        zero_reg[i+1]  <= zero_reg[i];
      end
      out_valid_o <= valid_reg[N];
      quotient_o  <= q_fix;
      remainder_o <= r_fix;
      div_zero_o  <= zero_reg[N];
      tag_o       <= tag_reg[N];
    end
  end

endmodule

// File: tb/tb_div_pipe_unit.sv
// Bench for div_pipe_unit: two instances (1 and 4 steps per stage) share one stimulus stream
// and are checked every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_pipe_unit;

  localparam int W    = 32;
  localparam int TW   = 6;
  localparam int LAT1 = 34;
  localparam int LAT4 = 10;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ce, in_valid, sgn;
  logic [W-1:0]  dividend, divisor;
  logic [TW-1:0] tag;
  logic          ov1, ov4, z1, z4;
  logic [W-1:0]  q1, r1, q4, r4;
  logic [TW-1:0] t1, t4;

  div_pipe_unit #(.WIDTH(W), .STEPS_PER_STAGE(1), .TAG_W(TW)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .ce_i(ce), .in_valid_i(in_valid),
    .dividend_i(dividend), .divisor_i(divisor), .signed_i(sgn), .tag_i(tag),
    .out_valid_o(ov1), .quotient_o(q1), .remainder_o(r1), .div_zero_o(z1), .tag_o(t1)
  );

  div_pipe_unit #(.WIDTH(W), .STEPS_PER_STAGE(4), .TAG_W(TW)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .ce_i(ce), .in_valid_i(in_valid),
    .dividend_i(dividend), .divisor_i(divisor), .signed_i(sgn), .tag_i(tag),
    .out_valid_o(ov4), .quotient_o(q4), .remainder_o(r4), .div_zero_o(z4), .tag_o(t4)
  );

  typedef struct packed {
    longint        due;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          z;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t   sb1[$];
  exp_t   sb4[$];
  longint e_cnt    = 0;
  int     n_assert = 0;
  int     n_fail   = 0;

  function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic [TW-1:0] t);
    exp_t   e;
    longint sa, sb;
    e = '0;
    e.tag = t;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (s) begin
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic check_one(input string nm, input bit have, input exp_t f, input logic ov,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic z,
                           input logic [TW-1:0] t);
    logic ev;
    ev = have && (f.due == e_cnt);
    n_assert++;
    assert (ov === ev) else begin
      n_fail++;
      $error("FAIL %s out_valid E=%0d: got %b expected %b", nm, e_cnt, ov, ev);
    end
    if (ev) begin
      $display("%s result tag=%0d q=%h r=%h z=%b", nm, t, q, r, z);
      n_assert++;
      assert ({q, r, z, t} === {f.q, f.r, f.z, f.tag}) else begin
        n_fail++;
        $error("FAIL %s result E=%0d: got q=%h r=%h z=%b tag=%0d expected q=%h r=%h z=%b tag=%0d",
               nm, e_cnt, q, r, z, t, f.q, f.r, f.z, f.tag);
      end
    end
  endtask

  task automatic check_all();
    exp_t f1, f4;
    bit   h1, h4;
    f1 = '0;
    f4 = '0;
    while (sb1.size() > 0 && sb1[0].due < e_cnt) void'(sb1.pop_front());
    while (sb4.size() > 0 && sb4[0].due < e_cnt) void'(sb4.pop_front());
    h1 = (sb1.size() > 0);
    h4 = (sb4.size() > 0);
    if (h1) f1 = sb1[0];
    if (h4) f4 = sb4[0];
    check_one("dut1", h1, f1, ov1, q1, r1, z1, t1);
    check_one("dut4", h4, f4, ov4, q4, r4, z4, t4);
  endtask

  // One clock: account the edge in the model, then sample outputs on the falling edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst_n && ce) begin
      e_cnt++;
      if (in_valid) begin
        e = ref_div(dividend, divisor, sgn && SIGNED_EN, tag);
        e.due = e_cnt + LAT1 - 1;
        sb1.push_back(e);
        e.due = e_cnt + LAT4 - 1;
        sb4.push_back(e);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] t);
    dividend = a;
    divisor  = b;
    sgn      = s;
    tag      = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rand_op(output logic [W-1:0] a, output logic [W-1:0] b);
    int sel;
    sel = $urandom_range(0, 9);
    a = $urandom;
    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
    case (sel)
      0:       b = '0;
      1, 2, 3: b = W'($urandom_range(1, 15));
      4:       b = '1;
      5:       b = ~W'($urandom_range(0, 14));
      default: b = $urandom >> $urandom_range(0, 31);
    endcase
  endtask

  task automatic check_reset_outputs(input string when_s);
    n_assert++;
    assert ({ov1, q1, r1, z1, t1} === '0) else begin
      n_fail++;
      $error("FAIL %s dut1 outputs: got v=%b q=%h r=%h z=%b tag=%0d expected all 0",
             when_s, ov1, q1, r1, z1, t1);
    end
    n_assert++;
    assert ({ov4, q4, r4, z4, t4} === '0) else begin
      n_fail++;
      $error("FAIL %s dut4 outputs: got v=%b q=%h r=%h z=%b tag=%0d expected all 0",
             when_s, ov4, q4, r4, z4, t4);
    end
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n    = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    tag      = '0;
    step();
    step();
    check_reset_outputs("power_on_reset");
    rst_n = 1'b1;

    // Directed operations, including sign cases and divide by zero.
    issue(32'd100, 32'd7, 1'b0, 6'd3);
    drain(LAT1 + 2);
    issue(-32'sd7, 32'd2, 1'b1, 6'd1);
    issue(32'd7, -32'sd2, 1'b1, 6'd2);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 6'd4);
    issue(32'd5, 32'd0, 1'b1, 6'd5);
    issue(32'd5, 32'd0, 1'b0, 6'd6);
    issue(32'd9, 32'd3, 1'b0, 6'd7);
    issue(-32'sd7, 32'd2, 1'b0, 6'd8);
    issue(32'hFFFF_FFFF, 32'd0, 1'b1, 6'd9);
    drain(LAT1 + 2);

    // 40 back-to-back random operations.
    for (int i = 0; i < 40; i++) begin
      rand_op(a, b);
      issue(a, b, 1'($urandom_range(0, 1)), TW'(i));
    end
    drain(LAT1 + 2);

    // Stream with a 5-cycle clock-enable drop; inputs during the stall must be ignored.
    for (int i = 0; i < 25; i++) begin
      rand_op(a, b);
      ce       = !(i >= 8 && i < 13);
      dividend = a;
      divisor  = b;
      sgn      = 1'($urandom_range(0, 1));
      tag      = TW'(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    ce       = 1'b1;
    drain(LAT1 + 2);

    // Reset with ten operations in flight.
    for (int i = 0; i < 10; i++) begin
      rand_op(a, b);
      issue(a, b, 1'($urandom_range(0, 1)), TW'(40 + i));
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midflight_reset");
    sb1.delete();
    sb4.delete();
    step();
    step();
    rst_n = 1'b1;
    issue(32'd9, 32'd3, 1'b0, 6'd11);
    drain(LAT1 + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
